// File: rtl/b1_pkg.sv
// Shared constants for the BeiDou B1I local replica: code length, LFSR
// initial state, G1/G2 feedback masks and the PRN phase-select table.
package b1_pkg;

  localparam int          B1_CODE_LEN  = 2046;
  localparam logic [10:0] B1_LFSR_INIT = 11'b01010101010;

  // Bit k holds stage k+1; stage 11 is the output end of the register.
  localparam logic [10:0] B1_G1_TAPS = 11'b11111000001;
  localparam logic [10:0] B1_G2_TAPS = 11'b10110011111;

  typedef struct packed {
    logic [3:0] tap1;
    logic [3:0] tap2;
  } b1_prn_taps_t;

  localparam b1_prn_taps_t B1_PRN_TAPS [1:37] = '{
    '{4'd1, 4'd3},  '{4'd1, 4'd4},  '{4'd1, 4'd5},  '{4'd1, 4'd6},
    '{4'd1, 4'd8},  '{4'd1, 4'd9},  '{4'd1, 4'd10}, '{4'd1, 4'd11},
    '{4'd2, 4'd7},  '{4'd3, 4'd4},  '{4'd3, 4'd5},  '{4'd3, 4'd6},
    '{4'd3, 4'd8},  '{4'd3, 4'd9},  '{4'd3, 4'd10}, '{4'd3, 4'd11},
    '{4'd4, 4'd5},  '{4'd4, 4'd6},  '{4'd4, 4'd8},  '{4'd4, 4'd9},
    '{4'd4, 4'd10}, '{4'd4, 4'd11}, '{4'd5, 4'd6},  '{4'd5, 4'd8},
    '{4'd5, 4'd9},  '{4'd5, 4'd10}, '{4'd5, 4'd11}, '{4'd6, 4'd8},
    '{4'd6, 4'd9},  '{4'd6, 4'd10}, '{4'd6, 4'd11}, '{4'd8, 4'd9},
    '{4'd8, 4'd10}, '{4'd8, 4'd11}, '{4'd9, 4'd10}, '{4'd9, 4'd11},
    '{4'd10, 4'd11}
  };

  function automatic logic [10:0] b1_lfsr_step(input logic [10:0] g,
                                                input logic [10:0] taps);
    return {g[9:0], ^(g & taps)};
  endfunction

endpackage

// File: rtl/b1_nco.sv
// 32-bit phase accumulator with loadable FCW working register, run enable
// and a registered overflow carry that is held while disabled.
module b1_nco #(
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [31:0]      fcw_i,
  output logic [OUT_W-1:0] acc_msb_o,
  output logic             carry_o
);

  logic [31:0] fcw_q, fcw_d;
  logic [31:0] acc_q, acc_d;
  logic        carry_q, carry_d;

  // Accumulate with the FCW held before this edge; a load takes effect next cycle.
  always_comb begin
    fcw_d   = fcw_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    if (en_i) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, fcw_q};
      if (ld_i) begin
        fcw_d = fcw_i;
      end else begin
        fcw_d = fcw_q;
      end
    end else begin
      carry_d = carry_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fcw_q   <= 32'd0;
      acc_q   <= 32'd0;
      carry_q <= 1'b0;
    end else begin
      fcw_q   <= fcw_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign acc_msb_o = acc_q[31 -: OUT_W];
  assign carry_o   = carry_q;

endmodule

// File: rtl/b1_loc_gen.sv
// B1I local replica generator: carrier NCO, code/subcarrier NCO, truncated
// Gold code generator and early/prompt/late BOC replica signs.
module b1_loc_gen
  import b1_pkg::*;
#(
  parameter int PH_W     = 8,
  parameter int PRN_TAP1 = 1,
  parameter int PRN_TAP2 = 3,
  parameter int CODE_LEN = B1_CODE_LEN
) (
  input  logic            rx_clk,
  input  logic            rx_rst,
  input  logic            rx_en,
  input  logic [31:0]     rx_car_fcw,
  input  logic [31:0]     rx_prn_fcw,
  input  logic            rx_fcw_vld,
  output logic            tx_loc_bocE,
  output logic            tx_loc_bocP,
  output logic            tx_loc_bocL,
  output logic            tx_prn_sop,
  output logic [PH_W-1:0] tx_car_phase,
  output logic [10:0]     tx_chip_cnt
);

  localparam logic [10:0] LAST_IDX = 11'(CODE_LEN - 1);

  logic [PH_W-1:0] car_phase_s;
  logic            car_carry_unused_s;
  logic            code_msb_unused_s;
  logic            code_carry_s;
  logic            tick_s;
  logic            chip_s;

  logic [10:0]     chip_idx_q, chip_idx_d;
  logic            s_q, s_d;
  logic [10:0]     g1_q, g1_d;
  logic [10:0]     g2_q, g2_d;
  logic            e_q, e_d, p_q, p_d, l_q, l_d;
  logic [10:0]     chip_cnt_q, chip_cnt_d;
  logic            sop_q, sop_d;
  logic            e_start_q, e_start_d;
  logic [PH_W-1:0] phase_q, phase_d;

  b1_nco #(.OUT_W(PH_W)) u_car_nco (
    .clk_i     (rx_clk),
    .rst_ni    (rx_rst),
    .en_i      (rx_en),
    .ld_i      (rx_fcw_vld),
    .fcw_i     (rx_car_fcw),
    .acc_msb_o (car_phase_s),
    .carry_o   (car_carry_unused_s)
  );

  b1_nco #(.OUT_W(1)) u_code_nco (
    .clk_i     (rx_clk),
    .rst_ni    (rx_rst),
    .en_i      (rx_en),
    .ld_i      (rx_fcw_vld),
    .fcw_i     (rx_prn_fcw),
    .acc_msb_o (code_msb_unused_s),
    .carry_o   (code_carry_s)
  );

  // A carry held across a disabled stretch is issued on the first enabled cycle.
  assign tick_s = rx_en & code_carry_s;
  assign chip_s = g1_q[10] ^ g2_q[PRN_TAP1-1] ^ g2_q[PRN_TAP2-1];

  // Generator next state: emit the pending subchip, then advance (chip, s, G1, G2).
  always_comb begin
    chip_idx_d = chip_idx_q;
    s_d        = s_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    e_d        = e_q;
    p_d        = p_q;
    l_d        = l_q;
    chip_cnt_d = chip_cnt_q;
    e_start_d  = e_start_q;
    sop_d      = 1'b0;
    phase_d    = rx_en ? car_phase_s : phase_q;
    if (tick_s) begin
      l_d        = p_q;
      p_d        = e_q;
      e_d        = chip_s ^ s_q;
      chip_cnt_d = chip_idx_q;
      s_d        = ~s_q;
      // E content after reset is the reset zero, so sop waits for a real chip 0.
      sop_d      = e_start_q;
      e_start_d  = (chip_idx_q == 11'd0) && !s_q;
      if (s_q) begin
        if (chip_idx_q == LAST_IDX) begin
          chip_idx_d = 11'd0;
          g1_d       = B1_LFSR_INIT;
          g2_d       = B1_LFSR_INIT;
        end else begin
          chip_idx_d = chip_idx_q + 11'd1;
          g1_d       = b1_lfsr_step(g1_q, B1_G1_TAPS);
          g2_d       = b1_lfsr_step(g2_q, B1_G2_TAPS);
        end
      end else begin
        chip_idx_d = chip_idx_q;
      end
    end else begin
      sop_d = 1'b0;
    end
  end

  // Generator and output registers.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      chip_idx_q <= 11'd0;
      s_q        <= 1'b0;
      g1_q       <= B1_LFSR_INIT;
      g2_q       <= B1_LFSR_INIT;
      e_q        <= 1'b0;
      p_q        <= 1'b0;
      l_q        <= 1'b0;
      chip_cnt_q <= 11'd0;
      sop_q      <= 1'b0;
      e_start_q  <= 1'b0;
      phase_q    <= '0;
    end else begin
      chip_idx_q <= chip_idx_d;
      s_q        <= s_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      e_q        <= e_d;
      p_q        <= p_d;
      l_q        <= l_d;
      chip_cnt_q <= chip_cnt_d;
      sop_q      <= sop_d;
      e_start_q  <= e_start_d;
      phase_q    <= phase_d;
    end
  end

  assign tx_loc_bocE  = e_q;
  assign tx_loc_bocP  = p_q;
  assign tx_loc_bocL  = l_q;
  assign tx_prn_sop   = sop_q;
  assign tx_car_phase = phase_q;
  assign tx_chip_cnt  = chip_cnt_q;

endmodule
